// File: rtl/add_share_pkg.sv
// rtl/add_share_pkg.sv - shared types and constants for the shared-adder arbiter
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DW       = 32;
  localparam int NREQ_MAX = 8;

  // Rotate an index by an offset inside a ring of n requesters.
  function automatic int wrap_idx(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/ADD.sv
// rtl/ADD.sv - combinational 32-bit adder shared by the datapath clients
module ADD (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] Out
);

  assign Out = in1 + in2;

endmodule

// File: rtl/add_rr_picker.sv
// rtl/add_rr_picker.sv - round-robin pick of the first valid requester at or after ptr
module add_rr_picker
  import add_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  pick,
  output logic            any_valid
);

  logic [IDW-1:0] w_idx;

  // Scan from the far end back toward ptr so the nearest valid requester wins.
  always_comb begin
    pick      = '0;
    w_idx     = '0;
    any_valid = |req_valid;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'(wrap_idx(int'(ptr), k, NREQ));
      if (req_valid[w_idx]) begin
        pick = w_idx;
      end
    end
  end

endmodule

// File: rtl/add_share_arbiter.sv
// rtl/add_share_arbiter.sv - round-robin sharing of one ADD unit among NREQ requesters
module add_share_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = add_share_pkg::DW,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [DW-1:0]      rsp_data,
  output logic               busy
);

  import add_share_pkg::*;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_rsp_id;
  logic [IDW-1:0]  w_pick;
  logic            w_any;
  logic [DW-1:0]   r_opa;
  logic [DW-1:0]   r_opb;
  logic [DW-1:0]   r_rsp_data;
  logic [DW-1:0]   w_sum;
  logic            r_rsp_valid;
  logic [NREQ-1:0] w_req_ready;

  add_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req_valid (req_valid),
    .ptr       (r_ptr),
    .pick      (w_pick),
    .any_valid (w_any)
  );

  // The adder only ever sees registered operands, so its input is stable for the EXEC cycle.
  ADD u_add (
    .in1 (r_opa),
    .in2 (r_opb),
    .Out (w_sum)
  );

  // Next state and grant; a grant is only offered while idle.
  always_comb begin
    w_next      = r_state;
    w_req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next      = EXEC;
          w_req_ready = NREQ'(1) << w_pick;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand capture on grant, result/response registration in EXEC, release on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_opa <= req_a[w_pick*DW +: DW];
            r_opb <= req_b[w_pick*DW +: DW];
            r_id  <= w_pick;
            r_ptr <= IDW'(wrap_idx(int'(w_pick), 1, NREQ));
          end
        end
        EXEC: begin
          r_rsp_data  <= w_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb/tb_add_share_arbiter.sv - scoreboard bench for the shared-adder arbiter
module tb_add_share_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int IDW  = 2;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_data;
  logic               busy;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   grant_cyc = 0;
  int   nrsp  = 0;

  add_share_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted response and checks invariants.
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_rsp got id=%0d data=%0h want none", rsp_id, rsp_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(rsp_id) != e.id || rsp_data !== e.data) begin
          bad++;
          $display("FAIL rsp%0d got id=%0d data=%0h want id=%0d data=%0h",
                   nrsp, rsp_id, rsp_data, e.id, e.data);
        end
      end
      nrsp++;
    end
    if (!$onehot0(req_ready) || (req_ready != 0 && busy) || (rsp_valid && !busy)) begin
      total++;
      bad++;
      $display("FAIL invariant got req_ready=%b busy=%b rsp_valid=%b want onehot0/idle-only grant",
               req_ready, busy, rsp_valid);
    end
  end

  task automatic wait_grant(output int g);
    g = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
        grant_cyc = cyc;
        break;
      end
    end
    if (g < 0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout got none want a grant");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic push_it, input logic [31:0] exp_sum);
    int g;
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
    if (push_it) q.push_back('{i, exp_sum});
    wait_grant(g);
    chk("grant_idx", 64'(g), 64'(i));
    req_valid[i] = 1'b0;
  endtask

  task automatic check_latency();
    @(negedge clk);
    chk("lat_exec_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_resp_rsp_valid", 64'(rsp_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got pending=%0d want 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int order[5];
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_ctrl", 64'({rsp_valid, busy, rsp_id, req_ready}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, wrap-around sums.
    issue(0, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0000_0000);
    check_latency();
    drain();
    issue(0, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h0000_0001);
    check_latency();
    drain();

    // All four valid continuously; ptr is 1 here after two grants to req 0.
    // Re-reset so the order starts from ptr=0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = 32'(i * 100);
      req_b[i*DW +: DW] = 32'(i);
    end
    order = '{0, 1, 2, 3, 0};
    q.push_back('{0, 32'd0});
    q.push_back('{1, 32'd101});
    q.push_back('{2, 32'd202});
    q.push_back('{3, 32'd303});
    q.push_back('{0, 32'd0});
    req_valid = '1;
    for (int n = 0; n < 5; n++) begin
      int prev;
      prev = grant_cyc;
      wait_grant(g);
      chk("all_grant_order", 64'(g), 64'(order[n]));
      if (n > 0) chk("all_grant_spacing", 64'(grant_cyc - prev), 64'd3);
    end
    req_valid = '0;
    drain();

    // Fairness: grant 1 (ptr->2), then 0 and 2 together -> 2 then 0.
    issue(1, 32'd1, 32'd1, 1'b1, 32'd2);
    drain();
    req_a[2*DW +: DW] = 32'd7;
    req_b[2*DW +: DW] = 32'd8;
    req_a[0*DW +: DW] = 32'd20;
    req_b[0*DW +: DW] = 32'd22;
    q.push_back('{2, 32'd15});
    q.push_back('{0, 32'd42});
    req_valid[0] = 1'b1;
    req_valid[2] = 1'b1;
    wait_grant(g);
    chk("fair_first", 64'(g), 64'd2);
    req_valid[2] = 1'b0;
    wait_grant(g);
    chk("fair_second", 64'(g), 64'd0);
    req_valid[0] = 1'b0;
    drain();

    // Backpressure: stall 5 cycles in RESP while req 3 waits.
    rsp_ready = 1'b0;
    issue(1, 32'd555, 32'd246, 1'b1, 32'd801);
    req_a[3*DW +: DW] = 32'd10;
    req_b[3*DW +: DW] = 32'd20;
    req_valid[3]      = 1'b1;
    q.push_back('{3, 32'd30});
    @(posedge clk);
    #1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_data", 64'(rsp_data), 64'd801);
      chk("stall_ctrl", 64'({rsp_valid, rsp_id, req_ready}), 64'({1'b1, 2'd1, 4'd0}));
      @(posedge clk);
    end
    #1;
    rsp_ready = 1'b1;
    wait_grant(g);
    chk("stall_next_grant", 64'(g), 64'd3);
    req_valid[3] = 1'b0;
    drain();

    // Reset during EXEC discards the transaction.
    issue(0, 32'd0, 32'd12345678, 1'b0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", 64'(rsp_data), 64'd0);
    chk("rst_async_ctrl", 64'({rsp_valid, busy, rsp_id, req_ready}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    issue(3, 32'd6, 32'd9, 1'b1, 32'd15);
    drain();

    // Idle with no requests.
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("idle_quiet", 64'({busy, req_ready, rsp_valid}), 64'd0);
    end

    chk("rsp_count", 64'(nrsp), 64'd13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
